amx_pipe_scheduler: RTL
=======================

Name: amx_pipe_scheduler

Overview:
- Shares one fixed-latency, non-stallable add-multiply-xor pipeline (dp_out = ((a+b)*c)^d, truncated to WIDTH) among NUM_REQ requesters.
- Round-robin arbitration issues at most one operation per cycle and drives the pipeline operands combinationally.
- Tracks the requester ID of each in-flight operation in a LATENCY-deep tag shift register and returns each result with its ID exactly LATENCY cycles after issue.
- Sits between client blocks and the shared 3-stage pipeline instance; the pipeline itself has no valid, stall or reset.

Parameters:
- WIDTH, 16, operand/result width.
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 3, clock edges from operands presented on dp_* to result on dp_out.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  issue enable; low blocks new grants, in-flight work still completes.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when req_valid[i] & req_ready[i].
- req_a, req_b, req_c, req_d  in  NUM_REQ*WIDTH each  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
- dp_a, dp_b, dp_c, dp_d  out  WIDTH each  operands to the shared pipeline.
- dp_out  in  WIDTH  pipeline result.
- rsp_valid  out  1  result valid.
- rsp_id  out  clog2(NUM_REQ)  requester owning the result.
- rsp_data  out  WIDTH  equals dp_out.
- busy  out  1  any operation in flight.
- inflight  out  clog2(LATENCY+1)  count of in-flight operations.

Behaviour:
- Reset (rst_n low at a rising edge):
  - All tag valids are cleared and the round-robin pointer is set to 0.
  - rsp_valid=0, rsp_id=0, busy=0, inflight=0.
  - req_ready is 0 while rst_n is low.
  - Reset mid-flight discards all outstanding operations; no rsp_valid is produced for them, even though the pipeline's internal data keeps shifting.
- Arbitration (combinational within a cycle):
  - If en=1 and rst_n=1 and req_valid!=0, grant the first requester with valid set, searching from ptr upward modulo NUM_REQ.
  - Set req_ready one-hot for that requester; otherwise req_ready=0.
  - req_ready never depends on req_ready, so there is no loop; it may depend on req_valid.
  - Requesters must hold operands stable while req_valid=1.
- Pointer: on a cycle with a grant to g, ptr <= (g+1) mod NUM_REQ at the edge. With no grant, ptr holds.
- Operand steering:
  - dp_a..dp_d = granted requester's operands.
  - When no grant, dp_* = 0, a deterministic idle value.
- Tag pipeline:
  - Stage 0 captures {grant_valid, g} at each edge; stage k captures stage k-1.
  - rsp_valid and rsp_id are driven from stage LATENCY-1, so an issue in cycle t gives rsp_valid=1 in cycle t+LATENCY with rsp_data = dp_out.
  - rsp_data is passed through unregistered.
  - Back-to-back issues produce back-to-back responses. There is no response backpressure; consumers must accept every rsp_valid.
- Counters:
  - inflight = number of set tag valids (0..LATENCY).
  - busy = (inflight != 0).
- Arithmetic is owned by the pipeline: a+b, the product and the xor are each truncated to WIDTH bits.
- en deasserted mid-stream: grants stop that cycle. busy falls LATENCY cycles after the last issue, in the cycle after the last rsp_valid.
- Simultaneous events: issue and retire in the same cycle leaves inflight unchanged.

Test Plan:
- Single op: requester 0 presents a=1, b=2, c=3, d=4 in cycle t. Required: req_ready=4'b0001 at t; rsp_valid at t+3 with rsp_id=0 and rsp_data=0x000D; busy high t+1..t+3.
- Add wrap, requester 2 presents a=0xFFFF, b=2, c=5, d=0 → rsp_data=0x0005, rsp_id=2. Multiply truncation: a=0x0100, b=0, c=0x0100, d=0xFFFF → 0xFFFF.
- Fairness: all 4 requesters hold req_valid for 8 cycles. Required: grants 0,1,2,3,0,1,2,3; 8 consecutive rsp_valid cycles with matching IDs; inflight saturates at 3.
- Pointer: after a grant to 1, requesters 0 and 3 become valid. Required: 3 is granted before 0.
- Drain: stream from requester 1, drop en at cycle t. Required: no req_ready from t on; responses for issues up to t-1 complete; busy=0 at t+3.
- Reset mid-flight: issue 3 ops, assert rst_n=0 for one edge after the 2nd issue. Required: no rsp_valid afterwards; inflight=0; ptr=0, so the next grant with all valid goes to requester 0.

Source files
------------

// File: rtl/amx_pipe_scheduler.sv
// Round-robin front end for one shared, fixed-latency add-multiply-xor pipeline.
// Grants at most one requester per cycle, steers its operands onto dp_*, and
// carries the requester ID alongside the pipeline so each result is returned
// with its owner exactly LATENCY cycles after issue.
module amx_pipe_scheduler #(
  parameter  int WIDTH   = 16,
  parameter  int NUM_REQ = 4,
  parameter  int LATENCY = 3,
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*WIDTH-1:0] req_c,
  input  logic [NUM_REQ*WIDTH-1:0] req_d,
  output logic [WIDTH-1:0]         dp_a,
  output logic [WIDTH-1:0]         dp_b,
  output logic [WIDTH-1:0]         dp_c,
  output logic [WIDTH-1:0]         dp_d,
  input  logic [WIDTH-1:0]         dp_out,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy,
  output logic [CNT_W-1:0]         inflight
);

  logic [ID_W-1:0]    ptr;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    cand;
  logic [LATENCY-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [LATENCY];

  // Round-robin search: first valid requester at or after ptr, modulo NUM_REQ.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    if (en && rst_n) begin
      // Walk from farthest to nearest so the nearest valid candidate wins last.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = ID_W'((int'(ptr) + k) % NUM_REQ);
        if (req_valid[cand]) begin
          grant_valid = 1'b1;
          grant_id    = cand;
        end
      end
    end
  end

  // One-hot grant and operand steering; idle operands are forced to zero.
  always_comb begin
    req_ready = '0;
    dp_a      = '0;
    dp_b      = '0;
    dp_c      = '0;
    dp_d      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_valid && grant_id == ID_W'(i)) begin
        req_ready[i] = 1'b1;
        dp_a         = req_a[i*WIDTH +: WIDTH];
        dp_b         = req_b[i*WIDTH +: WIDTH];
        dp_c         = req_c[i*WIDTH +: WIDTH];
        dp_d         = req_d[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer advances past the granted requester; holds when nothing issues.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag shift register tracking {valid, id} of each operation in the pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_v <= '0;
      // NOTE: the ID stages are reset as well (only LATENCY small entries) so rsp_id reads 0 after reset.
      for (int k = 0; k < LATENCY; k++) tag_id[k] <= '0;
    end else begin
      tag_v[0]  <= grant_valid;
      tag_id[0] <= grant_id;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  // Occupancy is the population count of the tag valids.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < LATENCY; k++) inflight = inflight + CNT_W'(tag_v[k]);
  end

  assign busy      = (inflight != '0);
  assign rsp_valid = tag_v[LATENCY-1];
  assign rsp_id    = tag_id[LATENCY-1];
  assign rsp_data  = dp_out;

endmodule
